// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/halfadder.sv
// One-bit half adder: e is the sum bit, f is the carry bit.
module halfadder (
    input  logic a,
    input  logic b,
    output logic e,
    output logic f
);

    assign e = a ^ b;
    assign f = a & b;

endmodule

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder built from two half adders.
// The carry-out is the OR of the two half-adder carries.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0_s;
    logic c0_s;
    logic c1_s;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .e (s0_s),
        .f (c0_s)
    );

    halfadder u_ha1 (
        .a (s0_s),
        .b (ci),
        .e (s),
        .f (c1_s)
    );

    assign co = c0_s | c1_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one bit per cycle, LSB first,
// taking WIDTH RUN cycles followed by a one-cycle DONE pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q;
    logic              done_q;
    logic              fa_sum_s;
    logic              fa_carry_s;

    fulladder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_sum_s),
        .co (fa_carry_s)
    );

    // Next-state and datapath update; subtraction is A + ~B + 1 via carry-in.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
                carry_d = fa_carry_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed corner cases,
// ignored starts, mid-run reset and 200 random back-to-back operations.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int due);
        exp_t e;
        logic [W:0] wide;
        if (s) begin
            wide = {1'b0, x} - {1'b0, y};
            e.s  = wide[W-1:0];
            e.c  = (x >= y);
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            e.s  = wide[W-1:0];
            e.c  = wide[W];
        end
        e.due = due;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec = n_vec + 1;
        if (got !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Drive one start; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit hold, input bit push, output exp_t e);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        e = model(x, y, s, cyc + W);
        if (push) q.push_back(e);
        if (!hold) start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic single_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        issue(x, y, s, 1'b0, 1'b1, e);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (W + 3) @(posedge clk);
        #1;
        check("sum_hold", {24'd0, sum}, {24'd0, e.s});
        check("cout_hold", {31'd0, cout}, {31'd0, e.c});
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: pops an expectation on each done pulse and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_vec = n_vec + 1;
            if (q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_done: got sum=%h cout=%b at cycle %0d, expected no done",
                         sum, cout, cyc);
            end else begin
                e = q.pop_front();
                if (sum !== e.s || cout !== e.c || cyc != e.due) begin
                    n_err = n_err + 1;
                    $display("FAIL result: got sum=%h cout=%b cycle=%0d, expected sum=%h cout=%b cycle=%0d",
                             sum, cout, cyc, e.s, e.c, e.due);
                end
            end
        end
    end

    initial begin
        exp_t e;
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {24'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        single_op(8'h0F, 8'h01, 1'b0);
        single_op(8'hFF, 8'h01, 1'b0);
        single_op(8'h05, 8'h07, 1'b1);
        single_op(8'h07, 8'h05, 1'b1);
        single_op(8'h00, 8'h00, 1'b1);

        // Starts during RUN and during DONE must be ignored.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, e);
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W - 3) @(posedge clk);
        #1;
        a = 8'hC3; b = 8'h3C; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        check("ignore_sum",  {24'd0, sum},  32'h46);
        check("ignore_cout", {31'd0, cout}, 32'd0);

        // Reset during RUN aborts; start right after release is accepted.
        issue(8'h81, 8'h7E, 1'b0, 1'b0, 1'b0, e);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_sum",  {24'd0, sum},  32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h33, 8'h44, 1'b1, 1'b0, 1'b1, e);
        repeat (W + 3) @(posedge clk);
        #1;
        check("post_rst_sum", {24'd0, sum}, {24'd0, e.s});

        // Random back-to-back operations with start held high.
        for (int i = 0; i < 200; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b1, e);
            repeat (W + 1) @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        while (q.size() != 0) begin
            e = q.pop_front();
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL missing_done: got no done, expected sum=%h cout=%b at cycle %0d",
                     e.s, e.c, e.due);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
